// File: rtl/event_counter_pkg.sv
// Shared types and constants for the event counter slice.
package event_counter_pkg;

  // Snapshot FSM: counting freely, or holding a snapshot for the consumer.
  typedef enum logic {
    ST_COUNT = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // Default counter / snapshot width in bits.
  localparam int DEFAULT_WIDTH = 4;

endpackage : event_counter_pkg

// File: rtl/event_counter_incr.sv
// Ripple incrementer: a chain of half adders with stage 0 fed a constant 1.
// Purely combinational. The result is WIDTH+1 bits, and the top bit is the carry out.
module incr_nbit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH:0]   sum
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] bit_sum;

  assign carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_half_adder
      // One half adder per bit. The carry ripples toward the MSB.
      assign bit_sum[gi]  = a[gi] ^ carry[gi];
      assign carry[gi+1]  = a[gi] & carry[gi];
    end
  endgenerate

  assign sum = {carry[WIDTH], bit_sum};

endmodule : incr_nbit

// File: rtl/event_counter.sv
// Counts rising edges of evt_in and snapshots the running count into a held
// output register. The consumer takes the snapshot with a valid/ready handshake.
// The live counter restarts from zero on capture without losing the capture-cycle edge.
module event_counter
  import event_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             evt_in,
  input  logic             clear,
  input  logic             cap_req,
  input  logic             cnt_ready,
  output logic             cnt_valid,
  output logic [WIDTH-1:0] cnt_data,
  output logic             cnt_ovf,
  output logic             busy
);

  logic             evt_q_reg;
  logic [WIDTH-1:0] count_reg;
  logic             ovf_live_reg;
  state_t           state_reg;
  state_t           state_next;

  logic             edge_det;
  logic             cap_accept;
  logic             handshake;
  logic [WIDTH:0]   sum;

  incr_nbit #(.WIDTH(WIDTH)) u_incr (
    .a   (count_reg),
    .sum (sum)
  );

  assign edge_det   = evt_in & ~evt_q_reg;
  assign cap_accept = (state_reg == ST_COUNT) & cap_req;
  assign handshake  = cnt_valid & cnt_ready;

  // Delay the event level by one cycle for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) evt_q_reg <= 1'b0;
    else     evt_q_reg <= evt_in;
  end

  // Live counter and sticky wrap flag. Clear beats capture, and capture beats a plain edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg    <= '0;
      ovf_live_reg <= 1'b0;
    end else if (clear || cap_accept) begin
      count_reg    <= '0;
      ovf_live_reg <= 1'b0;
    end else if (edge_det) begin
      count_reg    <= sum[WIDTH-1:0];
      ovf_live_reg <= ovf_live_reg | sum[WIDTH];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_COUNT;
    else     state_reg <= state_next;
  end

  // FSM next state: capture enters HOLD, and a completed handshake leaves it.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_COUNT: if (cap_req)   state_next = ST_HOLD;
      ST_HOLD:  if (handshake) state_next = ST_COUNT;
      default:                 state_next = ST_COUNT;
    endcase
  end

  // Snapshot registers. They load only on an accepted capture. A same-cycle edge is
  // folded in unless clear is also asserted, in which case that edge is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_valid <= 1'b0;
      cnt_data  <= '0;
      cnt_ovf   <= 1'b0;
    end else if (cap_accept) begin
      cnt_valid <= 1'b1;
      if (edge_det && !clear) begin
        cnt_data <= sum[WIDTH-1:0];
        cnt_ovf  <= ovf_live_reg | sum[WIDTH];
      end else begin
        cnt_data <= count_reg;
        cnt_ovf  <= ovf_live_reg;
      end
    end else if (handshake) begin
      cnt_valid <= 1'b0;
    end
  end

  assign busy = (state_reg == ST_HOLD);

endmodule : event_counter

// File: tb/tb_event_counter.sv
// Directed bench for event_counter. A reference model tracks the total number of
// events since the last restart as a plain integer. The snapshot is that total
// modulo 16, and the overflow flag is set when the total reaches 16 or more.
// The model is checked against the DUT on every cycle, and literal expectations
// pin each scenario.
module tb_event_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         evt_in = 1'b0;
  logic         clear = 1'b0;
  logic         cap_req = 1'b0;
  logic         cnt_ready = 1'b0;
  logic         cnt_valid;
  logic [W-1:0] cnt_data;
  logic         cnt_ovf;
  logic         busy;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  int m_events = 0;
  int m_valid  = 0;
  int m_data   = 0;
  int m_ovf    = 0;
  int m_prev   = 0;

  event_counter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .evt_in    (evt_in),
    .clear     (clear),
    .cap_req   (cap_req),
    .cnt_ready (cnt_ready),
    .cnt_valid (cnt_valid),
    .cnt_data  (cnt_data),
    .cnt_ovf   (cnt_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model update on each rising edge, then a check of every output on the following falling edge.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_events = 0; m_valid = 0; m_data = 0; m_ovf = 0; m_prev = 0;
      end else begin
        int edge_seen;
        int cap_ok;
        int snap_total;
        edge_seen = (evt_in && !m_prev) ? 1 : 0;
        m_prev    = evt_in ? 1 : 0;
        cap_ok    = (cap_req && !m_valid) ? 1 : 0;
        if (cap_ok != 0) begin
          snap_total = (edge_seen != 0 && !clear) ? m_events + 1 : m_events;
          m_data  = snap_total % 16;
          m_ovf   = (snap_total >= 16) ? 1 : 0;
          m_valid = 1;
        end else if (m_valid != 0 && cnt_ready) begin
          m_valid = 0;
        end
        if (clear || cap_ok != 0) m_events = 0;
        else if (edge_seen != 0)  m_events = m_events + 1;
      end
      @(negedge clk);
      check("model_valid", int'(cnt_valid), m_valid);
      check("model_data",  int'(cnt_data),  m_data);
      check("model_ovf",   int'(cnt_ovf),   m_ovf);
      check("model_busy",  int'(busy),      m_valid);
    end
  end

  // Apply one cycle of inputs starting from a falling edge, then return at the next falling edge.
  task automatic drive(input logic e, input logic cl, input logic cq, input logic rd, input logic r);
    evt_in = e; clear = cl; cap_req = cq; cnt_ready = rd; rst = r;
    @(negedge clk);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Capture with no same-cycle edge, then check the held snapshot.
  task automatic capture(input string name, input int exp_data, input int exp_ovf);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check({name, "_valid"}, int'(cnt_valid), 1);
    check({name, "_data"},  int'(cnt_data),  exp_data);
    check({name, "_ovf"},   int'(cnt_ovf),   exp_ovf);
  endtask

  task automatic handshake(input string name);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check({name, "_hs_valid"}, int'(cnt_valid), 0);
    check({name, "_hs_busy"},  int'(busy),      0);
  endtask

  initial begin
    @(negedge clk);
    // Reset with the event input toggling.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_valid", int'(cnt_valid), 0);
    check("rst_data",  int'(cnt_data),  0);
    check("rst_ovf",   int'(cnt_ovf),   0);
    check("rst_busy",  int'(busy),      0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    capture("rst_count", 0, 0);
    check("rst_cap_busy", int'(busy), 1);
    handshake("rst_count");

    // Count 5 events and capture; the live counter then restarts from zero.
    pulses(5);
    capture("five", 5, 0);
    handshake("five");
    capture("five_live0", 0, 0);
    handshake("five_live0");

    // 17 events wrap the 4-bit counter.
    pulses(17);
    capture("wrap", 1, 1);
    handshake("wrap");
    capture("wrap_next", 0, 0);
    handshake("wrap_next");

    // Backpressure: capture at 3, then hold for 10 cycles with 4 events and 2 ignored requests.
    pulses(3);
    capture("bp", 3, 0);
    for (int i = 0; i < 10; i++)
      drive((i < 8) && (i % 2 == 0), 1'b0, (i == 3) || (i == 7), 1'b0, 1'b0);
    check("bp_hold_valid", int'(cnt_valid), 1);
    check("bp_hold_data",  int'(cnt_data),  3);
    // A request in the handshake cycle is ignored.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("bp_hs_ignored", int'(cnt_valid), 0);
    capture("bp_next", 4, 0);
    handshake("bp_next");

    // An edge in the capture cycle joins the snapshot.
    pulses(2);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("edgecap_data", int'(cnt_data), 3);
    handshake("edgecap");
    capture("edgecap_live0", 0, 0);
    handshake("edgecap_live0");

    // An edge in the capture cycle at count 15 carries into the overflow flag.
    pulses(15);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("edgewrap_data", int'(cnt_data), 0);
    check("edgewrap_ovf",  int'(cnt_ovf),  1);
    handshake("edgewrap");

    // Clear together with capture (and an edge) snapshots the pre-clear count.
    pulses(6);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("clrcap_data", int'(cnt_data), 6);
    handshake("clrcap");
    capture("clrcap_live0", 0, 0);
    handshake("clrcap_live0");

    // Clear with an edge drops the edge, and holding evt_in high counts once.
    pulses(4);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    capture("clr_hold_level", 1, 0);
    handshake("clr_hold_level");

    // Clear while holding affects only the live counter.
    pulses(2);
    capture("hold_clr", 2, 0);
    pulses(3);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    pulses(1);
    check("hold_clr_data", int'(cnt_data), 2);
    handshake("hold_clr");
    capture("hold_clr_live", 1, 0);

    // Reset while holding drops the snapshot and returns to counting.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rsthold_valid", int'(cnt_valid), 0);
    check("rsthold_busy",  int'(busy),      0);
    check("rsthold_data",  int'(cnt_data),  0);
    capture("rsthold_recap", 0, 0);
    handshake("rsthold_recap");

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_event_counter

// File: doc/event_counter.md
# event_counter

Registered event counter that feeds a ripple incrementer and consumes its result. It counts rising edges on a single-bit event input. On request, it snapshots the count into a held output register with a valid/ready handshake. It then restarts from zero without losing events.

## Interface
- WIDTH, 4, counter and snapshot width in bits; incrementer result is WIDTH+1 bits.
- clk  in  1  rising-edge clock; only clock domain.
- rst  in  1  synchronous, active-high reset.
- evt_in  in  1  event level input, already synchronous to clk.
- clear  in  1  zeroes the live counter and the live overflow flag.
- cap_req  in  1  snapshot request; honoured only in ST_COUNT.
- cnt_ready  in  1  downstream accepts the snapshot.
- cnt_valid  out  1  snapshot held and valid.
- cnt_data  out  WIDTH  snapshot count.
- cnt_ovf  out  1  snapshot window wrapped at least once.
- busy  out  1  high in ST_HOLD, i.e. a capture is outstanding.

## Operation
- Edge detect: evt_q <= evt_in each cycle; edge = evt_in & ~evt_q.
- Incrementer input is live count; sum[WIDTH-1:0] is next count; sum[WIDTH] is carry.
- Live update, priority high to low:
  - rst: count = 0.
  - clear: count = 0, ovf_live = 0. A same-cycle edge is dropped.
  - capture accepted: count = 0, ovf_live = 0.
  - edge: count = sum, ovf_live |= carry.
- Counter wraps modulo 2^WIDTH. Overflow is sticky until capture, clear or rst.
- FSM states:
  - ST_COUNT: cap_req=1 moves to ST_HOLD, loads cnt_data and cnt_ovf, and sets cnt_valid=1.
  - ST_HOLD: cnt_valid & cnt_ready returns to ST_COUNT and clears cnt_valid. cap_req is ignored.
- Snapshot value:
  - With an edge in the capture cycle and no clear: cnt_data = sum, cnt_ovf = ovf_live | carry.
  - Otherwise: cnt_data = count, cnt_ovf = ovf_live.
- Capture and clear in the same cycle: the snapshot takes the pre-clear count, excluding the same-cycle edge. The live counter goes to 0.
- Counting continues in ST_HOLD. clear in ST_HOLD affects only the live counter, never held outputs.
- cnt_data and cnt_ovf stay stable while cnt_valid=1; they are unchanged after handshake until the next capture.

## Timing
- Reset values: cnt_valid=0, cnt_data=0, cnt_ovf=0, busy=0, state ST_COUNT, count=0, evt_q=0.
- Event latency: evt_in rising, sampled at edge N, makes count visible after edge N.
- Holding evt_in high counts once. Back-to-back events need evt_in low for at least one cycle between them.
- Capture latency: cap_req sampled at edge N gives cnt_valid=1 after edge N.
- Handshake: transfer happens on the edge where cnt_valid & cnt_ready = 1; cnt_valid=0 after it. Minimum capture interval is 2 cycles.
- cap_req in the handshake cycle is ignored, because the state is still ST_HOLD.
- rst mid-HOLD drops the snapshot with no handshake.
- All outputs are registered except busy, which decodes the state register.

## Structure
- event_counter_pkg holds:
  - state enum: ST_COUNT, ST_HOLD.
  - default width constant: 4.
- Sub-module incr_nbit (WIDTH parameter):
  - a WIDTH-stage ripple chain of half adders; stage 0 is fed constant 1.
  - output is the WIDTH+1-bit sum; combinational, no clock.
- The top module holds evt_q, the live count and ovf_live, the FSM, and the snapshot registers.

## Test plan
- Reset: drive rst=1 with evt_in toggling for 3 cycles -> all outputs 0, count stays 0 after release.
- Count and capture: 5 pulses, then cap_req, then cnt_ready=1 -> cnt_valid=1, cnt_data=5, cnt_ovf=0 for one cycle; live count 0.
- Wrap: 17 pulses with WIDTH=4, then capture -> cnt_data=1, cnt_ovf=1; next capture with 0 pulses -> cnt_data=0, cnt_ovf=0.
- Backpressure: capture at count 3, cnt_ready=0 for 10 cycles with 4 pulses and 2 cap_req meanwhile -> cnt_data holds 3; after handshake, next capture gives 4.
- Simultaneous events:
  - edge with cap_req at count 2 -> snapshot 3, live 0.
  - clear with cap_req at count 6 -> snapshot 6, live 0.
  - clear with edge -> live 0.
- Reset mid-HOLD: rst while cnt_valid=1 -> cnt_valid=0 next cycle, no transfer, state ST_COUNT.
